// File: rtl/hwpe_cfg_master.sv
// Config-port initiator for an HWPE accelerator: acquires a context, writes the job registers,
// triggers the job and waits for its completion event (or times out and soft-clears).
module hwpe_cfg_master #(
    parameter int unsigned N_JOB_REGS = 8,
    parameter int unsigned ID_WIDTH   = 10,
    parameter int unsigned MASTER_ID  = 0,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned RETRY_WAIT = 16,
    parameter int unsigned TIMEOUT    = 65536
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     job_valid_i,
    output logic                     job_ready_o,
    input  logic [N_JOB_REGS*32-1:0] job_regs_i,
    output logic                     done_o,
    output logic                     err_o,
    output logic [7:0]               job_id_o,
    output logic                     req_o,
    input  logic                     gnt_i,
    output logic [31:0]              add_o,
    output logic                     wen_o,
    output logic [3:0]               be_o,
    output logic [31:0]              data_o,
    output logic [ID_WIDTH-1:0]      id_o,
    input  logic [31:0]              r_data_i,
    input  logic                     r_valid_i,
    input  logic                     evt_i
);

    localparam int unsigned    IdxW        = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(N_JOB_REGS - 1);
    localparam logic [31:0]    RetryLast   = 32'(RETRY_WAIT - 1);
    localparam logic [31:0]    TimeoutLast = 32'(TIMEOUT - 1);
    localparam logic [31:0]    OffTrig     = 32'h00;
    localparam logic [31:0]    OffAcq      = 32'h04;
    localparam logic [31:0]    OffClr      = 32'h14;
    localparam logic [31:0]    OffJob      = 32'h40;

    typedef enum logic [3:0] {
        StIdle,
        StAcqReq,
        StAcqRsp,
        StBackoff,
        StWrReq,
        StWrRsp,
        StTrigReq,
        StTrigRsp,
        StWaitEvt,
        StClrReq,
        StClrRsp,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [N_JOB_REGS*32-1:0] regs_q, regs_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [31:0]              cnt_q, cnt_d;
    logic [7:0]               job_id_q, job_id_d;
    logic                     err_q, err_d;

    // Only the busy flag and the context id of the acquire response are meaningful.
    logic unused_rdata;
    assign unused_rdata = ^r_data_i[30:8];

    assign be_o     = 4'hF;
    assign id_o     = ID_WIDTH'(MASTER_ID);
    assign job_id_o = job_id_q;

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        job_id_d    = job_id_q;
        err_d       = err_q;
        req_o       = 1'b0;
        wen_o       = 1'b1;
        add_o       = '0;
        data_o      = '0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        job_ready_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                job_ready_o = 1'b1;
                if (job_valid_i) begin
                    regs_d  = job_regs_i;
                    state_d = StAcqReq;
                end
            end
            StAcqReq: begin
                req_o = 1'b1;
                add_o = BASE_ADDR + OffAcq;
                if (gnt_i) state_d = StAcqRsp;
            end
            StAcqRsp: begin
                if (r_valid_i) begin
                    if (r_data_i[31]) begin
                        cnt_d   = '0;
                        state_d = StBackoff;
                    end else begin
                        job_id_d = r_data_i[7:0];
                        idx_d    = '0;
                        state_d  = StWrReq;
                    end
                end
            end
            StBackoff: begin
                if (cnt_q == RetryLast) state_d = StAcqReq;
                else                    cnt_d   = cnt_q + 32'd1;
            end
            StWrReq: begin
                req_o  = 1'b1;
                wen_o  = 1'b0;
                add_o  = BASE_ADDR + OffJob + (32'(idx_q) << 2);
                data_o = regs_q[32*idx_q +: 32];
                if (gnt_i) state_d = StWrRsp;
            end
            StWrRsp: begin
                if (r_valid_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = StTrigReq;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StWrReq;
                    end
                end
            end
            StTrigReq: begin
                req_o = 1'b1;
                wen_o = 1'b0;
                add_o = BASE_ADDR + OffTrig;
                if (gnt_i) state_d = StTrigRsp;
            end
            StTrigRsp: begin
                if (r_valid_i) begin
                    cnt_d   = '0;
                    state_d = StWaitEvt;
                end
            end
            StWaitEvt: begin
                // The event takes priority over a timeout expiring in the same cycle.
                if (evt_i) begin
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (TIMEOUT != 0 && cnt_q == TimeoutLast) begin
                    state_d = StClrReq;
                end else if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StClrReq: begin
                req_o = 1'b1;
                wen_o = 1'b0;
                add_o = BASE_ADDR + OffClr;
                if (gnt_i) state_d = StClrRsp;
            end
            StClrRsp: begin
                if (r_valid_i) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            regs_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            job_id_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            regs_q   <= regs_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            job_id_q <= job_id_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_hwpe_cfg_master.sv
// Bench for hwpe_cfg_master: reactive config slave, job-level transaction model and a per-cycle
// compare process, plus literal checks on the directed jobs.
module tb_hwpe_cfg_master;

    localparam int unsigned NR   = 8;
    localparam int unsigned IDW  = 10;
    localparam int unsigned MID  = 5;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned RW   = 5;
    localparam int unsigned TO   = 100;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              job_valid_i;
    logic              job_ready_o;
    logic [NR*32-1:0]  job_regs_i;
    logic              done_o;
    logic              err_o;
    logic [7:0]        job_id_o;
    logic              req_o;
    logic              gnt_i;
    logic [31:0]       add_o;
    logic              wen_o;
    logic [3:0]        be_o;
    logic [31:0]       data_o;
    logic [IDW-1:0]    id_o;
    logic [31:0]       r_data_i;
    logic              r_valid_i;
    logic              evt_i;

    hwpe_cfg_master #(
        .N_JOB_REGS (NR),
        .ID_WIDTH   (IDW),
        .MASTER_ID  (MID),
        .BASE_ADDR  (BASE),
        .RETRY_WAIT (RW),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .job_valid_i (job_valid_i),
        .job_ready_o (job_ready_o),
        .job_regs_i  (job_regs_i),
        .done_o      (done_o),
        .err_o       (err_o),
        .job_id_o    (job_id_o),
        .req_o       (req_o),
        .gnt_i       (gnt_i),
        .add_o       (add_o),
        .wen_o       (wen_o),
        .be_o        (be_o),
        .data_o      (data_o),
        .id_o        (id_o),
        .r_data_i    (r_data_i),
        .r_valid_i   (r_valid_i),
        .evt_i       (evt_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] data;
        int          gap;   // idle cycles between previous response and req rise, -1 = don't care
    } txn_t;

    txn_t        exp_q[$];
    txn_t        log_q[$];
    logic [31:0] acq_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          busy = 0;
    bit          outst = 0;
    logic [31:0] out_addr;
    logic        out_wen;
    int          last_rv_cyc = 0;
    bit          exp_err;
    logic [7:0]  exp_jid;
    int          exp_done_gap;
    bit          done_seen = 0;
    bit          last_err;
    logic [7:0]  last_jid;
    bit          stall_mode = 0;
    int          evt_d = -1;
    bit          evt_wr = 0;
    int          fire_a = -1;
    int          fire_b = -1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Config slave: grants and responds with zero wait or random 0-7 cycle stalls.
    initial begin
        bit pend, acc, acc_acq, pend_acq;
        int gwait, rwait;
        pend = 0; acc = 0; acc_acq = 0; pend_acq = 0; gwait = -1; rwait = 0;
        gnt_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_ni) begin
                pend = 0; acc = 0; gwait = -1;
                gnt_i = 1'b0; r_valid_i = 1'b0;
            end else begin
                r_valid_i = 1'b0;
                r_data_i  = $urandom;
                if (acc) begin
                    pend     = 1;
                    pend_acq = acc_acq;
                    rwait    = stall_mode ? int'($urandom_range(0, 7)) : 0;
                end
                if (pend) begin
                    if (rwait == 0) begin
                        r_valid_i = 1'b1;
                        pend      = 0;
                        if (pend_acq)
                            r_data_i = (acq_q.size() > 0) ? acq_q.pop_front()
                                                          : {1'b0, 23'($urandom), 8'($urandom)};
                    end else begin
                        rwait--;
                    end
                end else if (!acc && stall_mode && !req_o && $urandom_range(0, 7) == 0) begin
                    // Stray response outside any response phase; must be ignored.
                    r_valid_i = 1'b1;
                    r_data_i  = 32'h8000_0000 | $urandom;
                end
                if (req_o && !pend) begin
                    if (gwait < 0) gwait = stall_mode ? int'($urandom_range(0, 7)) : 0;
                    if (gwait == 0) begin
                        gnt_i = 1'b1;
                        gwait = -1;
                    end else begin
                        gnt_i = 1'b0;
                        gwait--;
                    end
                end else begin
                    gnt_i = 1'b0;
                end
                acc     = req_o && gnt_i;
                acc_acq = wen_o && (add_o == BASE + 32'h4);
            end
        end
    end

    initial begin
        evt_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            evt_i = rst_ni && (cyc == fire_a || cyc == fire_b);
        end
    end

    // Compare process: every cycle against the job-level model.
    initial begin
        bit          prev_req, prev_gnt, prev_wen;
        logic [31:0] prev_add, prev_data;
        txn_t        e;
        prev_req = 0; prev_gnt = 0; prev_wen = 1; prev_add = '0; prev_data = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_req = 0;
                outst    = 0;
            end else begin
                chk("job_ready", job_ready_o, !busy);
                if (req_o) begin
                    chk("be", be_o, 4'hF);
                    chk("id", id_o, IDW'(MID));
                    chk("overlap", outst, 0);
                end
                if (prev_req && !prev_gnt) begin
                    chk("req_hold", req_o, 1);
                    chk("add_hold", add_o, prev_add);
                    chk("wen_hold", wen_o, prev_wen);
                    chk("data_hold", data_o, prev_data);
                end
                if (req_o && !prev_req && exp_q.size() > 0 && exp_q[0].gap >= 0)
                    chk("req_gap", cyc - last_rv_cyc - 1, exp_q[0].gap);
                if (req_o && gnt_i) begin
                    chk("txn_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("txn_addr", add_o, e.addr);
                        chk("txn_wen", wen_o, e.wen);
                        if (!e.wen) chk("txn_data", data_o, e.data);
                    end
                    log_q.push_back('{add_o, wen_o, data_o, 0});
                    outst    = 1;
                    out_addr = add_o;
                    out_wen  = wen_o;
                    if (evt_wr && !wen_o && add_o == BASE + 32'h48) fire_b = cyc + 1;
                end
                if (r_valid_i && outst) begin
                    outst       = 0;
                    last_rv_cyc = cyc;
                    if (!out_wen && out_addr == BASE && evt_d > 0) fire_a = cyc + evt_d;
                end
                if (done_o) begin
                    chk("done_in_job", busy, 1);
                    chk("done_all_txns", exp_q.size(), 0);
                    chk("done_err", err_o, exp_err);
                    chk("done_job_id", job_id_o, exp_jid);
                    chk("done_gap", cyc - last_rv_cyc - 1, exp_done_gap);
                    last_err  = err_o;
                    last_jid  = job_id_o;
                    done_seen = 1;
                    busy      = 0;
                end else if (err_o) begin
                    chk("err_without_done", err_o, 0);
                end
                if (job_valid_i && job_ready_o) busy = 1;
                prev_req  = req_o;
                prev_gnt  = gnt_i;
                prev_add  = add_o;
                prev_wen  = wen_o;
                prev_data = data_o;
            end
        end
    end

    // Expected transaction list for one job, derived from the job-level rules.
    task automatic prep_job(input logic [NR*32-1:0] regs, input int n_busy,
                            input logic [31:0] busy_val, input logic [31:0] final_acq,
                            input int d, input bit wr_pulse);
        bit to;
        exp_q.delete();
        log_q.delete();
        acq_q.delete();
        for (int i = 0; i < n_busy; i++) acq_q.push_back(busy_val);
        acq_q.push_back(final_acq);
        for (int i = 0; i <= n_busy; i++)
            exp_q.push_back('{BASE + 32'h4, 1'b1, 32'h0, (i == 0) ? -1 : int'(RW)});
        for (int i = 0; i < int'(NR); i++)
            exp_q.push_back('{BASE + 32'h40 + 32'(4 * i), 1'b0, regs[32*i +: 32], 0});
        exp_q.push_back('{BASE, 1'b0, 32'h0, 0});
        to = !(d >= 1 && d <= int'(TO));
        if (to) exp_q.push_back('{BASE + 32'h14, 1'b0, 32'h0, int'(TO)});
        exp_err      = to;
        exp_jid      = final_acq[7:0];
        exp_done_gap = to ? 0 : d;
        evt_d        = d;
        evt_wr       = wr_pulse;
        fire_a       = -1;
        fire_b       = -1;
        done_seen    = 0;
    endtask

    task automatic submit(input logic [NR*32-1:0] regs);
        @(posedge clk_i);
        #1;
        job_regs_i  = regs;
        job_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        job_valid_i = 1'b0;
        job_regs_i  = {NR{$urandom}};
    endtask

    task automatic flush_model();
        exp_q.delete();
        busy   = 0;
        outst  = 0;
        fire_a = -1;
        fire_b = -1;
    endtask

    task automatic run_job(input logic [NR*32-1:0] regs, input int n_busy,
                           input logic [31:0] busy_val, input logic [31:0] final_acq,
                           input int d, input bit wr_pulse);
        int n;
        prep_job(regs, n_busy, busy_val, final_acq, d, wr_pulse);
        submit(regs);
        n = 0;
        while (!done_seen && n < 2000) begin
            @(posedge clk_i);
            n++;
        end
        chk("done_within_bound", done_seen, 1);
        if (!done_seen) begin
            #2 rst_ni = 1'b0;
            flush_model();
            repeat (2) @(posedge clk_i);
            @(negedge clk_i);
            rst_ni = 1'b1;
        end
        repeat (2) @(posedge clk_i);
    endtask

    task automatic check_reset_outputs();
        chk("rst_req", req_o, 0);
        chk("rst_wen", wen_o, 1);
        chk("rst_add", add_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_job_id", job_id_o, 0);
        chk("rst_ready", job_ready_o, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [NR*32-1:0] regs;
        int n, nreads, d;
        rst_ni      = 1'b0;
        job_valid_i = 1'b0;
        job_regs_i  = '0;
        repeat (3) @(posedge clk_i);
        #1 check_reset_outputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);

        // Zero-wait slave, regs = i*0x11, event 5 cycles after trigger.
        for (int i = 0; i < int'(NR); i++) regs[32*i +: 32] = 32'(i * 17);
        run_job(regs, 0, 32'h0, 32'h0000_12A5, 5, 1'b0);
        chk("t1_txn_count", log_q.size(), 10);
        if (log_q.size() == 10) begin
            chk("t1_acq_addr", log_q[0].addr, 32'h04);
            chk("t1_acq_wen", log_q[0].wen, 1);
            chk("t1_first_wr_addr", log_q[1].addr, 32'h40);
            chk("t1_first_wr_data", log_q[1].data, 32'h00);
            chk("t1_last_wr_addr", log_q[8].addr, 32'h5C);
            chk("t1_last_wr_data", log_q[8].data, 32'h77);
            chk("t1_trig_addr", log_q[9].addr, 32'h00);
            chk("t1_trig_wen", log_q[9].wen, 0);
        end
        chk("t1_job_id", last_jid, 8'hA5);
        chk("t1_err", last_err, 0);

        // Two busy acquire responses, then context 3.
        run_job(regs, 2, 32'hFFFF_FFFF, 32'h0000_0003, 5, 1'b0);
        nreads = 0;
        foreach (log_q[i]) if (log_q[i].wen) nreads++;
        chk("t2_acq_reads", nreads, 3);
        chk("t2_job_id", last_jid, 8'h03);

        // Random stalls, same write sequence.
        stall_mode = 1;
        run_job(regs, 0, 32'h0, 32'h0000_005A, 7, 1'b0);
        chk("t3_txn_count", log_q.size(), 10);
        if (log_q.size() == 10)
            for (int i = 0; i < int'(NR); i++) chk("t3_wr_data", log_q[1+i].data, 32'(i * 17));

        // No event: timeout and soft clear.
        stall_mode = 0;
        run_job(regs, 0, 32'h0, 32'h0000_0077, -1, 1'b0);
        chk("t4_txn_count", log_q.size(), 11);
        if (log_q.size() == 11) chk("t4_clr_addr", log_q[10].addr, 32'h14);
        chk("t4_err", last_err, 1);

        // Event during a write response (ignored) and on the timeout-limit cycle (wins).
        run_job(regs, 0, 32'h0, 32'h0000_0021, int'(TO), 1'b1);
        chk("t5_txn_count", log_q.size(), 10);
        chk("t5_err", last_err, 0);

        // Reset while waiting for a write response.
        for (int i = 0; i < int'(NR); i++) regs[32*i +: 32] = $urandom;
        prep_job(regs, 0, 32'h0, 32'h0000_0042, 10, 1'b0);
        submit(regs);
        n = 0;
        while (log_q.size() < 4 && n < 200) begin
            @(posedge clk_i);
            n++;
        end
        chk("t6_reached_wr", log_q.size() >= 4, 1);
        #2 rst_ni = 1'b0;
        flush_model();
        #1 check_reset_outputs();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_job(regs, 1, 32'h8000_1234, 32'h0000_0099, 20, 1'b0);
        chk("t6_restart_acq_addr", log_q.size() > 0 ? log_q[0].addr : 32'hDEAD, 32'h04);
        chk("t6_job_id", last_jid, 8'h99);

        // Random jobs with stalls, retries, spurious events and occasional timeouts.
        stall_mode = 1;
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < int'(NR); i++) regs[32*i +: 32] = $urandom;
            d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, TO));
            run_job(regs, int'($urandom_range(0, 2)), 32'h8000_0000 | $urandom,
                    {1'b0, 31'($urandom)}, d, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
